kairo_ifetch: RTL

Instruction fetch unit directly upstream of the SoC memory interface's instruction port. It generates sequential word addresses on the I_MEM request channel and absorbs the fixed 1-cycle READY/RDATA response into a small prefetch FIFO. It presents {pc, inst, excpt} to the decode stage over a valid/ready handshake and supports PC redirect with flush of queued and in-flight fetches.

---
 rtl/kairo_ifetch_pkg.sv | 18 +
 rtl/kairo_ifetch_if.sv | 31 +++
 rtl/kairo_ifetch_fifo.sv | 54 +++++
 rtl/kairo_ifetch.sv | 126 ++++++++++++
 4 files changed

// File: rtl/kairo_ifetch_pkg.sv
// Shared types and constants for the kairo_ifetch instruction fetch unit.
package kairo_ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excpt;
    } ifetch_entry_t;

    localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/kairo_ifetch_if.sv
// Redirect, decode-side handshake and I_MEM request/response signals of kairo_ifetch.
interface kairo_ifetch_if;

    logic        REDIRECT_VALID;
    logic [31:0] REDIRECT_PC;
    logic        INST_VALID;
    logic        INST_READY;
    logic [31:0] INST_PC;
    logic [31:0] INST_DATA;
    logic        INST_EXCPT;
    logic        I_MEM_VALID;
    logic [31:0] I_MEM_ADDR;
    logic [31:0] I_MEM_WDATA;
    logic [3:0]  I_MEM_WSTB;
    logic        I_MEM_READY;
    logic [31:0] I_MEM_RDATA;
    logic        I_MEM_EXCPT;

    modport master (
        input  REDIRECT_VALID, REDIRECT_PC, INST_READY, I_MEM_READY, I_MEM_RDATA, I_MEM_EXCPT,
        output INST_VALID, INST_PC, INST_DATA, INST_EXCPT,
        output I_MEM_VALID, I_MEM_ADDR, I_MEM_WDATA, I_MEM_WSTB
    );

    modport slave (
        output REDIRECT_VALID, REDIRECT_PC, INST_READY, I_MEM_READY, I_MEM_RDATA, I_MEM_EXCPT,
        input  INST_VALID, INST_PC, INST_DATA, INST_EXCPT,
        input  I_MEM_VALID, I_MEM_ADDR, I_MEM_WDATA, I_MEM_WSTB
    );

endinterface

// File: rtl/kairo_ifetch_fifo.sv
// Registered prefetch FIFO of fetch entries; flush beats push, head is read from storage.
module kairo_ifetch_fifo
    import kairo_ifetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic                          i_flush,
    input  ifetch_entry_t                 i_data,
    output ifetch_entry_t                 o_data,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_occ
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    ifetch_entry_t r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_occ;
    logic          w_pop;
    logic          w_full;

    assign o_empty = (r_occ == '0);
    assign w_full  = (r_occ == (AW+1)'(FIFO_DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_occ   = r_occ;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_occ <= r_occ + (AW+1)'(i_push) - (AW+1)'(w_pop);
        end
    end

    // Request throttling upstream makes a push into a full, non-draining FIFO impossible.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && w_full && !w_pop && !i_flush));

endmodule

// File: rtl/kairo_ifetch.sv
// Sequential instruction fetch with prefetch FIFO, redirect/flush and fault halt.
// Optional STALL_CNT output enabled by defining KAIRO_IFETCH_STALL_CNT_EN.
module kairo_ifetch
    import kairo_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic           CLK,
    input  logic           RST_N,
    kairo_ifetch_if.master bus
`ifdef KAIRO_IFETCH_STALL_CNT_EN
    ,
    output logic [31:0]    STALL_CNT
`endif
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   r_req_pc;
    logic          r_inflight;
    logic          r_drop;
    logic          w_drop_nxt;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [31:0]   w_pending;
    logic [31:0]   w_redirect_pc;
    logic [$clog2(FIFO_DEPTH):0] w_occ;
    ifetch_entry_t w_head;
    ifetch_entry_t w_wr_entry;

    assign w_redirect_pc = bus.REDIRECT_PC & ~32'h3;
    assign w_pop         = ~w_empty & bus.INST_READY;
    assign w_pending     = 32'(w_occ) + 32'(r_inflight) - 32'(w_pop);
    // Responses are only accepted while fetching; redirect and drop discard them.
    assign w_push        = bus.I_MEM_READY & ~r_drop & ~bus.REDIRECT_VALID & (r_state == FETCH);
    assign w_wr_entry    = '{pc: r_req_pc, inst: bus.I_MEM_RDATA, excpt: bus.I_MEM_EXCPT};

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_issue        = 1'b0;
        w_drop_nxt     = bus.I_MEM_READY ? 1'b0 : r_drop;
        if (bus.REDIRECT_VALID) begin
            w_state_nxt    = FETCH;
            w_fetch_pc_nxt = w_redirect_pc;
            w_drop_nxt     = r_inflight & ~bus.I_MEM_READY;
        end else begin
            unique case (r_state)
                IDLE: w_state_nxt = FETCH;
                FETCH: begin
                    if (w_pending < 32'(FIFO_DEPTH)) begin
                        w_issue        = 1'b1;
                        w_fetch_pc_nxt = r_fetch_pc + 32'(INST_BYTES);
                    end
                    if (w_push && bus.I_MEM_EXCPT) begin
                        w_state_nxt = HALT;
                    end
                end
                HALT: w_state_nxt = HALT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_inflight <= w_issue;
            r_drop     <= w_drop_nxt;
            if (w_issue) begin
                r_req_pc <= r_fetch_pc;
            end
        end
    end

    kairo_ifetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.REDIRECT_VALID),
        .i_data  (w_wr_entry),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_occ   (w_occ)
    );

    assign bus.INST_VALID  = ~w_empty;
    assign bus.INST_PC     = w_empty ? 32'd0 : w_head.pc;
    assign bus.INST_DATA   = w_empty ? 32'd0 : w_head.inst;
    assign bus.INST_EXCPT  = ~w_empty & w_head.excpt;
    assign bus.I_MEM_VALID = w_issue;
    assign bus.I_MEM_ADDR  = r_fetch_pc;
    assign bus.I_MEM_WDATA = 32'd0;
    assign bus.I_MEM_WSTB  = 4'd0;

`ifdef KAIRO_IFETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_stall_cnt <= '0;
        end else if ((r_state == FETCH) && w_empty && !bus.REDIRECT_VALID &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`endif

endmodule
